// File: rtl/signed_pow2_divider_pipe.sv
// Pipelined signed divide by 2**S with floor or truncate-toward-zero rounding.
// SW shift stages (stage k shifts by 2**k) feed one rounding-correction stage.
module signed_pow2_divider_pipe #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shift,
    input  logic          up_mode,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data,
    output logic          down_inexact
);

    localparam int L = SW + 1;

    logic [L-1:0]        valid_q, valid_d, ready_c;
    logic signed [N-1:0] data_q [L];
    logic signed [N-1:0] data_d [L];
    logic                sticky_q [L];
    logic                sticky_d [L];
    logic [SW-1:0]       shift_q [SW];
    logic [SW-1:0]       shift_d [SW];
    logic                mode_q [SW];
    logic                mode_d [SW];
    logic                sign_q [SW];
    logic                sign_d [SW];

    logic                in_valid [SW];
    logic signed [N-1:0] in_data [SW];
    logic [SW-1:0]       in_shift [SW];
    logic                in_mode [SW];
    logic                in_sign [SW];
    logic                in_sticky [SW];

    // A stage can accept when it is empty or its occupant moves on this cycle.
    function automatic logic [L-1:0] ready_chain(input logic [L-1:0] v, input logic dr);
        logic [L-1:0] r;
        logic         nxt;
        r   = '0;
        nxt = dr;
        for (int i = L - 1; i >= 0; i--) begin
            r[i] = !v[i] || nxt;
            nxt  = r[i];
        end
        return r;
    endfunction

    function automatic logic signed [N-1:0] asr_sat(input logic signed [N-1:0] a, input int sh);
        if (sh >= N) return {N{a[N-1]}};
        return a >>> sh;
    endfunction

    function automatic logic lost_bits(input logic signed [N-1:0] a, input int sh);
        logic [N-1:0] mask;
        if (sh >= N) return |a;
        mask = ~({N{1'b1}} << sh);
        return |(a & mask);
    endfunction

    function automatic logic signed [N-1:0] trunc_fix(input logic signed [N-1:0] q, input logic fix);
        return fix ? q + {{(N-1){1'b0}}, 1'b1} : q;
    endfunction

    assign ready_c = ready_chain(valid_q, down_ready);

    always_comb begin
        in_valid[0]  = up_valid;
        in_data[0]   = up_data;
        in_shift[0]  = up_shift;
        in_mode[0]   = up_mode;
        in_sign[0]   = up_data[N-1];
        in_sticky[0] = 1'b0;
        for (int k = 1; k < SW; k++) begin
            in_valid[k]  = valid_q[k-1];
            in_data[k]   = data_q[k-1];
            in_shift[k]  = shift_q[k-1];
            in_mode[k]   = mode_q[k-1];
            in_sign[k]   = sign_q[k-1];
            in_sticky[k] = sticky_q[k-1];
        end
    end

    always_comb begin
        logic [SW-1:0] rem;
        rem     = '0;
        valid_d = valid_q;
        for (int k = 0; k < L; k++) begin
            data_d[k]   = data_q[k];
            sticky_d[k] = sticky_q[k];
        end
        for (int k = 0; k < SW; k++) begin
            shift_d[k] = shift_q[k];
            mode_d[k]  = mode_q[k];
            sign_d[k]  = sign_q[k];
        end

        // ---- shift stages: stage k applies bit k of S ----
        for (int k = 0; k < SW; k++) begin
            if (ready_c[k]) begin
                valid_d[k] = in_valid[k];
                if (in_valid[k]) begin
                    rem        = in_shift[k] >> k;
                    shift_d[k] = in_shift[k];
                    mode_d[k]  = in_mode[k];
                    sign_d[k]  = in_sign[k];
                    if (rem[0]) begin
                        data_d[k]   = asr_sat(in_data[k], 1 << k);
                        sticky_d[k] = in_sticky[k] | lost_bits(in_data[k], 1 << k);
                    end else begin
                        data_d[k]   = in_data[k];
                        sticky_d[k] = in_sticky[k];
                    end
                end
            end
        end

        // ---- correction stage: floor result nudged toward zero when truncating ----
        if (ready_c[SW]) begin
            valid_d[SW] = valid_q[SW-1];
            if (valid_q[SW-1]) begin
                data_d[SW]   = trunc_fix(data_q[SW-1],
                                         mode_q[SW-1] && sign_q[SW-1] && sticky_q[SW-1]);
                sticky_d[SW] = sticky_q[SW-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < L; k++) begin
                data_q[k]   <= '0;
                sticky_q[k] <= 1'b0;
            end
            for (int k = 0; k < SW; k++) begin
                shift_q[k] <= '0;
                mode_q[k]  <= 1'b0;
                sign_q[k]  <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < L; k++) begin
                data_q[k]   <= data_d[k];
                sticky_q[k] <= sticky_d[k];
            end
            for (int k = 0; k < SW; k++) begin
                shift_q[k] <= shift_d[k];
                mode_q[k]  <= mode_d[k];
                sign_q[k]  <= sign_d[k];
            end
        end
    end

    assign up_ready     = ready_c[0];
    assign down_valid   = valid_q[SW];
    assign down_data    = data_q[SW];
    assign down_inexact = sticky_q[SW];

endmodule

// File: tb/tb_signed_pow2_divider_pipe.sv
// Directed and randomized checks of signed_pow2_divider_pipe (N=8) against an
// integer-division reference model.
module tb_signed_pow2_divider_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       up_valid;
    logic       up_ready;
    logic [7:0] up_data;
    logic [2:0] up_shift;
    logic       up_mode;
    logic       down_valid;
    logic       down_ready;
    logic [7:0] down_data;
    logic       down_inexact;

    int         vectors = 0;
    int         miscompares = 0;
    logic [8:0] exp_q[$];
    int         first_out, last_out, n_out;

    signed_pow2_divider_pipe #(.N(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_valid     (up_valid),
        .up_ready     (up_ready),
        .up_data      (up_data),
        .up_shift     (up_shift),
        .up_mode      (up_mode),
        .down_valid   (down_valid),
        .down_ready   (down_ready),
        .down_data    (down_data),
        .down_inexact (down_inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: floor via arithmetic shift of a 32-bit int, truncate via C-style divide.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [2:0] s, input logic m);
        int ai, d, q;
        ai = int'($signed(a));
        d  = 1 << s;
        if (m) q = ai / d;
        else   q = ai >>> s;
        return {(ai % d) != 0, q[7:0]};
    endfunction

    task automatic run_vec(input string tag, input logic [7:0] a, input logic [2:0] s,
                           input logic m, input logic [7:0] eq, input logic ei);
        int lat;
        down_ready = 1'b1;
        up_valid   = 1'b1;
        up_data    = a;
        up_shift   = s;
        up_mode    = m;
        #1;
        check({tag, "_rdy"}, up_ready, 1);
        @(posedge clk); #1;
        up_valid = 1'b0;
        lat = 1;
        while (!down_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, 4);
        check({tag, "_q"}, down_data, eq);
        check({tag, "_inx"}, down_inexact, ei);
        @(posedge clk); #1;
    endtask

    task automatic run_phase(input string tag, input int ncyc, input int vpct,
                             input int rpct, input int nmax);
        int         acc = 0;
        logic       pending = 1'b0;
        logic       held = 1'b0;
        logic [8:0] hold_val = '0;
        logic [8:0] front;
        first_out = -1;
        last_out  = -1;
        n_out     = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (!pending) begin
                if (acc < nmax && $urandom_range(99) < vpct) begin
                    up_valid = 1'b1;
                    up_data  = 8'($urandom);
                    up_shift = 3'($urandom);
                    up_mode  = 1'($urandom);
                end else begin
                    up_valid = 1'b0;
                end
            end
            down_ready = ($urandom_range(99) < rpct);
            #1;
            check({tag, "_up_ready"}, up_ready, down_ready || (exp_q.size() < 4));
            if (held) begin
                check({tag, "_hold_v"}, down_valid, 1);
                check({tag, "_hold_d"}, {down_inexact, down_data}, hold_val);
            end
            if (down_valid) begin
                if (first_out < 0) first_out = c;
                last_out = c;
                if (down_ready) begin
                    if (exp_q.size() == 0) begin
                        check({tag, "_extra_out"}, {down_inexact, down_data}, 9'h1ff ^ {down_inexact, down_data});
                    end else begin
                        front = exp_q.pop_front();
                        check({tag, "_out"}, {down_inexact, down_data}, front);
                        n_out++;
                    end
                end
            end
            held     = down_valid && !down_ready;
            hold_val = {down_inexact, down_data};
            if (up_valid && up_ready) begin
                exp_q.push_back(model(up_data, up_shift, up_mode));
                acc++;
                pending = 1'b0;
            end else begin
                pending = up_valid;
            end
            @(posedge clk); #1;
        end
        up_valid = 1'b0;
    endtask

    initial begin
        int outs;
        rst_n      = 1'b0;
        up_valid   = 1'b0;
        up_data    = '0;
        up_shift   = '0;
        up_mode    = 1'b0;
        down_ready = 1'b1;
        #2;
        check("rst_down_valid", down_valid, 0);
        check("rst_down_data", down_data, 0);
        check("rst_down_inexact", down_inexact, 0);
        check("rst_up_ready", up_ready, 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_vec("floor_m7_s1", 8'hF9, 3'd1, 1'b0, 8'hFC, 1'b1);
        run_vec("floor_20_s2", 8'h14, 3'd2, 1'b0, 8'h05, 1'b0);
        run_vec("trunc_m7_s1", 8'hF9, 3'd1, 1'b1, 8'hFD, 1'b1);
        run_vec("trunc_m1_s3", 8'hFF, 3'd3, 1'b1, 8'h00, 1'b1);
        run_vec("floor_m1_s3", 8'hFF, 3'd3, 1'b0, 8'hFF, 1'b1);
        run_vec("floor_min_s7", 8'h80, 3'd7, 1'b0, 8'hFF, 1'b0);
        run_vec("trunc_min_s7", 8'h80, 3'd7, 1'b1, 8'hFF, 1'b0);
        run_vec("floor_max_s0", 8'h7F, 3'd0, 1'b0, 8'h7F, 1'b0);
        run_vec("trunc_max_s0", 8'h7F, 3'd0, 1'b1, 8'h7F, 1'b0);
        run_vec("trunc_m5_s0", 8'hFB, 3'd0, 1'b1, 8'hFB, 1'b0);
        run_vec("trunc_m9_s2", 8'hF7, 3'd2, 1'b1, 8'hFE, 1'b1);
        run_vec("trunc_100_s5", 8'h64, 3'd5, 1'b1, 8'h03, 1'b1);

        // Fill the pipe while stalled, then reset with four transactions in flight.
        down_ready = 1'b0;
        up_valid   = 1'b1;
        up_shift   = 3'd1;
        up_mode    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_data = 8'(8'h21 + i);
            @(posedge clk); #1;
        end
        up_valid = 1'b0;
        check("pre_rst_full_v", down_valid, 1);
        check("pre_rst_full_rdy", up_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_down_valid", down_valid, 0);
        check("midrst_down_data", down_data, 0);
        check("midrst_up_ready", up_ready, 1);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        down_ready = 1'b1;
        outs = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (down_valid) outs++;
        end
        check("post_rst_outputs", outs, 0);

        exp_q.delete();
        run_phase("stream", 110, 100, 100, 100);
        check("stream_first", first_out, 4);
        check("stream_last", last_out, 103);
        check("stream_count", n_out, 100);
        check("stream_left", exp_q.size(), 0);

        run_phase("bp", 400, 60, 50, 1000);
        run_phase("drain", 20, 0, 100, 0);
        check("bp_left", exp_q.size(), 0);
        check("bp_idle_valid", down_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
